// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART register-port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default register address / data widths
//   arb_state_t             : arbiter FSM states
//   REG_*                   : UART register addresses used by sequencers
package uart_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [3:0] REG_CONFIG   = 4'd4;
  localparam logic [3:0] REG_TX_DATA  = 4'd7;
  localparam logic [3:0] REG_BAUD_DIV = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : per-requester request vector
//   ptr   : index of the last winner; scanning starts at ptr+1
//   win   : one-hot winner (zero when nothing is requested)
//   valid : at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // First set request scanning ptr+1, ptr+2, ... wrapping modulo N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = PTR_W'((int'(ptr) + k) % int'(N_REQ));
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_reg_arbiter.sv
// Round-robin arbiter sharing the single UART register port among N_REQ
// requesters, with locked multi-beat bursts capped at MAX_BURST beats while
// others wait.
//   clk, reset           : clock, synchronous active-low reset
//   req/lock/wr          : per-requester request, burst lock, beat type (1=write)
//   addr/wdata           : packed per-requester address and write data
//   gnt                  : registered one-hot grant
//   rvalid/rdata         : read-data pulse per requester, shared captured data
//   uart_write/uart_addr/uart_data_in : muxed register port toward the UART
//   uart_data_out        : read data returned by the UART
module uart_reg_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ-1:0]        wr,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    uart_write,
  output logic [ADDR_W-1:0]       uart_addr,
  output logic [DATA_W-1:0]       uart_data_in,
  input  logic [DATA_W-1:0]       uart_data_out
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t        state, state_n;
  logic [N_REQ-1:0]  gnt_n, rvalid_n, win;
  logic [PTR_W-1:0]  ptr, ptr_n, win_idx;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [DATA_W-1:0] rdata_n, data_hold, sel_wdata;
  logic [ADDR_W-1:0] addr_hold, sel_addr;
  logic              sel_req, sel_lock, sel_wr;
  logic              beat, others, pick_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (win),
    .valid (pick_valid)
  );

  // Owner's request fields and winner index, selected by constant slices.
  always_comb begin
    sel_req   = 1'b0;
    sel_lock  = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    win_idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        sel_req   = req[i];
        sel_lock  = lock[i];
        sel_wr    = wr[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
      if (win[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  // A beat is suppressed while reset is asserted so no UART write escapes.
  assign beat         = reset && (state == GRANT) && sel_req;
  assign others       = |(req & ~gnt);
  assign uart_write   = beat && sel_wr;
  assign uart_addr    = beat ? sel_addr  : addr_hold;
  assign uart_data_in = beat ? sel_wdata : data_hold;
  assign cnt_inc      = (cnt == MAX_CNT) ? cnt : cnt + CNT_W'(1);

  // Next-state, grant, beat counting and read capture.
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    ptr_n    = ptr;
    cnt_n    = cnt;
    rvalid_n = '0;
    rdata_n  = rdata;
    case (state)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_n = GRANT;
          gnt_n   = win;
          ptr_n   = win_idx;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          cnt_n = cnt_inc;
          if (!sel_wr) begin
            rvalid_n = gnt;
            rdata_n  = uart_data_out;
          end
        end
        // Saturated count only forces release once someone else is waiting.
        if (!sel_req || !sel_lock || ((cnt_inc == MAX_CNT) && others)) begin
          state_n = GAP;
          gnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // State and output registers; address/data hold the last beat's values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      ptr       <= PTR_W'(N_REQ - 1);
      cnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      rvalid <= rvalid_n;
      rdata  <= rdata_n;
      if (beat) begin
        addr_hold <= sel_addr;
        data_hold <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Directed bench for uart_reg_arbiter with a small UART register model.
module tb_uart_reg_arbiter;
  import uart_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req, lock, wr;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        uart_write;
  logic [3:0]  uart_addr;
  logic [31:0] uart_data_in;
  logic [31:0] uart_data_out;

  int n_pass  = 0;
  int n_total = 0;
  int base;

  logic [31:0] ureg [16];
  logic [31:0] wlog [$];

  logic [1:0]  exp_g [12];
  logic        exp_w [12];
  logic        f_r0  [12];
  logic        f_r1  [12];
  logic [31:0] f_d0  [12];
  logic [31:0] exp_log [7];

  uart_reg_arbiter #(
    .N_REQ     (2),
    .ADDR_W    (4),
    .DATA_W    (32),
    .MAX_BURST (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .lock          (lock),
    .wr            (wr),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .uart_write    (uart_write),
    .uart_addr     (uart_addr),
    .uart_data_in  (uart_data_in),
    .uart_data_out (uart_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART register file model plus a log of every write strobe.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) ureg[i] <= '0;
    end else if (uart_write) begin
      ureg[uart_addr] <= uart_data_in;
      wlog.push_back(uart_data_in);
    end
  end

  assign uart_data_out = ureg[uart_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic setr(input int i, input logic r, input logic l, input logic w,
                      input logic [3:0] a, input logic [31:0] d);
    req[i]            = r;
    lock[i]           = l;
    wr[i]             = w;
    addr[i*4 +: 4]    = a;
    wdata[i*32 +: 32] = d;
  endtask

  task automatic apply_reset();
    nxt();
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    wr    = '0;
    nxt();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;

    // Reset state
    nxt();
    nxt();
    mid();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_uwr", 32'(uart_write), 32'd0);
    chk("rst_uaddr", 32'(uart_addr), 32'd0);
    chk("rst_udata", uart_data_in, 32'd0);
    nxt();
    reset = 1'b1;
    mid();
    chk("rel_gnt", 32'(gnt), 32'd0);
    chk("rel_uwr", 32'(uart_write), 32'd0);

    // Locked write burst config / divisor / tx data, then divisor read-back
    base = wlog.size();
    nxt();
    setr(0, 1'b1, 1'b1, 1'b1, REG_CONFIG, 32'd5);
    mid();
    chk("b_gnt_latency", 32'(gnt), 32'd0);
    nxt();
    mid();
    chk("b1_gnt", 32'(gnt), 32'd1);
    chk("b1_uwr", 32'(uart_write), 32'd1);
    chk("b1_uaddr", 32'(uart_addr), 32'd4);
    chk("b1_udata", uart_data_in, 32'd5);
    nxt();
    setr(0, 1'b1, 1'b1, 1'b1, REG_BAUD_DIV, 32'd1024);
    mid();
    chk("b2_uwr", 32'(uart_write), 32'd1);
    chk("b2_uaddr", 32'(uart_addr), 32'd9);
    chk("b2_udata", uart_data_in, 32'd1024);
    nxt();
    setr(0, 1'b1, 1'b1, 1'b1, REG_TX_DATA, 32'h4000_0000);
    mid();
    chk("b3_uwr", 32'(uart_write), 32'd1);
    chk("b3_uaddr", 32'(uart_addr), 32'd7);
    chk("b3_udata", uart_data_in, 32'h4000_0000);
    nxt();
    setr(0, 1'b0, 1'b0, 1'b1, REG_TX_DATA, 32'h4000_0000);
    mid();
    chk("b_drop_gnt", 32'(gnt), 32'd1);
    chk("b_drop_uwr", 32'(uart_write), 32'd0);
    chk("b_hold_uaddr", 32'(uart_addr), 32'd7);
    nxt();
    setr(0, 1'b1, 1'b0, 1'b0, REG_BAUD_DIV, 32'd0);
    mid();
    chk("b_gap_gnt", 32'(gnt), 32'd0);
    nxt();
    mid();
    chk("rd9_gnt", 32'(gnt), 32'd1);
    chk("rd9_uwr", 32'(uart_write), 32'd0);
    chk("rd9_rvalid_early", 32'(rvalid), 32'd0);
    nxt();
    setr(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    mid();
    chk("rd9_rvalid", 32'(rvalid), 32'd1);
    chk("rd9_rdata", rdata, 32'd1024);
    nxt();
    mid();
    chk("rd9_pulse", 32'(rvalid), 32'd0);
    chk("b_nwr", 32'(wlog.size() - base), 32'd3);
    chk("b_log0", wlog[base], 32'd5);
    chk("b_log1", wlog[base+1], 32'd1024);
    chk("b_log2", wlog[base+2], 32'h4000_0000);

    // Contention: two single-beat requesters alternate with a GAP between
    apply_reset();
    setr(0, 1'b1, 1'b0, 1'b1, REG_CONFIG, 32'h11);
    setr(1, 1'b1, 1'b0, 1'b1, REG_TX_DATA, 32'h22);
    exp_g[0:7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
    exp_w[0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      mid();
      chk($sformatf("cont_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
      chk($sformatf("cont_uwr%0d", k), 32'(uart_write), 32'(exp_w[k]));
      nxt();
    end
    req = '0;

    // Fairness cap: req0 locked with 6 writes, req1 arrives at beat 2
    apply_reset();
    base  = wlog.size();
    f_r0  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    f_r1  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    f_d0  = '{32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4,
              32'hA4, 32'hA4, 32'hA4, 32'hA5, 32'hA5, 32'hA5};
    exp_g = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    exp_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_log = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hA4, 32'hA5};
    for (int c = 0; c < 12; c++) begin
      setr(0, f_r0[c], 1'b1, 1'b1, REG_TX_DATA, f_d0[c]);
      setr(1, f_r1[c], 1'b0, 1'b1, REG_TX_DATA, 32'hB0);
      mid();
      chk($sformatf("fair_gnt%0d", c), 32'(gnt), 32'(exp_g[c]));
      chk($sformatf("fair_uwr%0d", c), 32'(uart_write), 32'(exp_w[c]));
      nxt();
    end
    chk("fair_nwr", 32'(wlog.size() - base), 32'd7);
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("fair_log%0d", j), wlog[base+j], exp_log[j]);
    end

    // Read: req0 writes config=5, req1 reads it back
    apply_reset();
    setr(0, 1'b1, 1'b0, 1'b1, REG_CONFIG, 32'd5);
    setr(1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    nxt();
    mid();
    chk("rd_wr_gnt", 32'(gnt), 32'd1);
    chk("rd_wr_uwr", 32'(uart_write), 32'd1);
    nxt();
    setr(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    setr(1, 1'b1, 1'b0, 1'b0, REG_CONFIG, 32'd0);
    mid();
    chk("rd_gap_gnt", 32'(gnt), 32'd0);
    nxt();
    mid();
    chk("rd_gnt", 32'(gnt), 32'd2);
    chk("rd_uwr", 32'(uart_write), 32'd0);
    chk("rd_uaddr", 32'(uart_addr), 32'd4);
    chk("rd_rvalid_beat", 32'(rvalid), 32'd0);
    nxt();
    setr(1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    mid();
    chk("rd_rvalid", 32'(rvalid), 32'd2);
    chk("rd_rdata", rdata, 32'd5);
    nxt();
    mid();
    chk("rd_pulse", 32'(rvalid), 32'd0);

    // Reset during the second beat of a locked burst
    base = wlog.size();
    nxt();
    setr(0, 1'b1, 1'b1, 1'b1, REG_TX_DATA, 32'hC0);
    mid();
    chk("mr_idle_gnt", 32'(gnt), 32'd0);
    nxt();
    mid();
    chk("mr_b1_gnt", 32'(gnt), 32'd1);
    chk("mr_b1_uwr", 32'(uart_write), 32'd1);
    nxt();
    setr(0, 1'b1, 1'b1, 1'b1, REG_TX_DATA, 32'hC1);
    reset = 1'b0;
    mid();
    chk("mr_rst_uwr", 32'(uart_write), 32'd0);
    nxt();
    reset = 1'b1;
    setr(1, 1'b1, 1'b0, 1'b1, REG_TX_DATA, 32'hD0);
    mid();
    chk("mr_after_gnt", 32'(gnt), 32'd0);
    chk("mr_after_uwr", 32'(uart_write), 32'd0);
    chk("mr_after_rdata", rdata, 32'd0);
    chk("mr_after_rvalid", 32'(rvalid), 32'd0);
    nxt();
    mid();
    chk("mr_first_gnt", 32'(gnt), 32'd1);
    chk("mr_first_uwr", 32'(uart_write), 32'd1);
    chk("mr_first_udata", uart_data_in, 32'hC1);
    chk("mr_nwr", 32'(wlog.size() - base), 32'd1);
    chk("mr_log0", wlog[base], 32'hC0);
    nxt();
    req = '0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
